alu_reservation_station: RTL and testbench

- Out-of-order ALU issue queue. Sits directly downstream of the serialized writeback broadcast.
- Accepts one dispatched ALU µop per cycle from the decoder/renamer.
- Snoops the single writeback bus (en/vregid/val) to wake up pending source operands.
- Issues at most one ready µop per cycle to the ALU as a registered output.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/rs_find_first.sv | 24 ++
 rtl/alu_reservation_station.sv | 166 ++++++++++++++++
 tb/tb_alu_reservation_station.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-wide widths and the ALU opcode set used by decoder, RS and ALU.
package cpu_pkg;

  localparam int unsigned CPU_VREG_W = 5;
  localparam int unsigned CPU_DATA_W = 32;
  localparam int unsigned CPU_OP_W   = 5;

  typedef enum logic [CPU_OP_W-1:0] {
    AluAdd  = 5'd0,
    AluSub  = 5'd1,
    AluAnd  = 5'd2,
    AluOr   = 5'd3,
    AluXor  = 5'd4,
    AluSll  = 5'd5,
    AluSrl  = 5'd6,
    AluSra  = 5'd7,
    AluSlt  = 5'd8,
    AluSltu = 5'd9
  } alu_op_e;

endpackage

// File: rtl/rs_find_first.sv
// Find-first-set priority encoder: lowest set bit of req wins.
module rs_find_first #(
  parameter int unsigned DEPTH = 8
) (
  input  logic [DEPTH-1:0]         req,
  output logic                     found,
  output logic [$clog2(DEPTH)-1:0] idx
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  // Scan from the top down so the lowest-index request is the last one written.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/alu_reservation_station.sv
// ALU reservation station: in-order slot allocation, writeback snooping wakeup,
// lowest-index-ready issue into a registered output stage.
module alu_reservation_station
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned VREG_W = CPU_VREG_W,
  parameter int unsigned DATA_W = CPU_DATA_W,
  parameter int unsigned OP_W   = CPU_OP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              dispatch_en,
  input  logic [OP_W-1:0]   dispatch_op,
  input  logic              dispatch_rs1_ready,
  input  logic [VREG_W-1:0] dispatch_rs1_vregid,
  input  logic [DATA_W-1:0] dispatch_rs1_val,
  input  logic              dispatch_rs2_ready,
  input  logic [VREG_W-1:0] dispatch_rs2_vregid,
  input  logic [DATA_W-1:0] dispatch_rs2_val,
  input  logic [VREG_W-1:0] dispatch_dst_vregid,
  output logic              full,
  input  logic              wb_en,
  input  logic [VREG_W-1:0] wb_vregid,
  input  logic [DATA_W-1:0] wb_val,
  output logic              issue_en,
  output logic [OP_W-1:0]   issue_op,
  output logic [DATA_W-1:0] issue_val1,
  output logic [DATA_W-1:0] issue_val2,
  output logic [VREG_W-1:0] issue_dst_vregid
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic              valid;
    logic [OP_W-1:0]   op;
    logic [VREG_W-1:0] dst;
    logic              rdy1;
    logic [VREG_W-1:0] tag1;
    logic [DATA_W-1:0] val1;
    logic              rdy2;
    logic [VREG_W-1:0] tag2;
    logic [DATA_W-1:0] val2;
  } entry_t;

  entry_t entry_q [DEPTH];
  entry_t entry_d [DEPTH];
  entry_t new_entry;

  logic [DEPTH-1:0] free_vec;
  logic [DEPTH-1:0] ready_vec;
  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;

  // Occupancy and readiness vectors from registered state only.
  always_comb begin
    free_vec  = '0;
    ready_vec = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      free_vec[i]  = ~entry_q[i].valid;
      ready_vec[i] = entry_q[i].valid & entry_q[i].rdy1 & entry_q[i].rdy2;
    end
  end

  assign full = ~|free_vec;

  rs_find_first #(.DEPTH(DEPTH)) u_free_sel (
    .req   (free_vec),
    .found (free_found),
    .idx   (free_idx)
  );

  rs_find_first #(.DEPTH(DEPTH)) u_issue_sel (
    .req   (ready_vec),
    .found (sel_found),
    .idx   (sel_idx)
  );

  // Incoming entry, with same-cycle writeback bypass for unready sources.
  always_comb begin
    new_entry       = '0;
    new_entry.valid = 1'b1;
    new_entry.op    = dispatch_op;
    new_entry.dst   = dispatch_dst_vregid;
    new_entry.rdy1  = dispatch_rs1_ready;
    new_entry.tag1  = dispatch_rs1_vregid;
    new_entry.val1  = dispatch_rs1_val;
    new_entry.rdy2  = dispatch_rs2_ready;
    new_entry.tag2  = dispatch_rs2_vregid;
    new_entry.val2  = dispatch_rs2_val;
    if (wb_en && !dispatch_rs1_ready && dispatch_rs1_vregid == wb_vregid) begin
      new_entry.rdy1 = 1'b1;
      new_entry.val1 = wb_val;
    end
    if (wb_en && !dispatch_rs2_ready && dispatch_rs2_vregid == wb_vregid) begin
      new_entry.rdy2 = 1'b1;
      new_entry.val2 = wb_val;
    end
  end

  // Next entry state: wakeup, then issue clear, then allocation, with flush overriding all.
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      entry_d[i] = entry_q[i];
      if (entry_q[i].valid && wb_en) begin
        if (!entry_q[i].rdy1 && entry_q[i].tag1 == wb_vregid) begin
          entry_d[i].rdy1 = 1'b1;
          entry_d[i].val1 = wb_val;
        end
        if (!entry_q[i].rdy2 && entry_q[i].tag2 == wb_vregid) begin
          entry_d[i].rdy2 = 1'b1;
          entry_d[i].val2 = wb_val;
        end
      end
    end
    if (sel_found) begin
      entry_d[sel_idx].valid = 1'b0;
    end
    // free_idx never equals sel_idx: a selected entry is valid, hence not free.
    if (dispatch_en && free_found) begin
      entry_d[free_idx] = new_entry;
    end
    if (flush) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        entry_d[i].valid = 1'b0;
      end
    end
  end

  // Entry storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      entry_q <= entry_d;
    end
  end

  // Registered issue stage; payload holds its last value when nothing issues.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_en         <= 1'b0;
      issue_op         <= '0;
      issue_val1       <= '0;
      issue_val2       <= '0;
      issue_dst_vregid <= '0;
    end else if (flush) begin
      issue_en <= 1'b0;
    end else begin
      issue_en <= sel_found;
      if (sel_found) begin
        issue_op         <= entry_q[sel_idx].op;
        issue_val1       <= entry_q[sel_idx].val1;
        issue_val2       <= entry_q[sel_idx].val2;
        issue_dst_vregid <= entry_q[sel_idx].dst;
      end
    end
  end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed, table-driven bench for alu_reservation_station.
module tb_alu_reservation_station;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        dispatch_en;
  logic [4:0]  dispatch_op;
  logic        dispatch_rs1_ready;
  logic [4:0]  dispatch_rs1_vregid;
  logic [31:0] dispatch_rs1_val;
  logic        dispatch_rs2_ready;
  logic [4:0]  dispatch_rs2_vregid;
  logic [31:0] dispatch_rs2_val;
  logic [4:0]  dispatch_dst_vregid;
  logic        full;
  logic        wb_en;
  logic [4:0]  wb_vregid;
  logic [31:0] wb_val;
  logic        issue_en;
  logic [4:0]  issue_op;
  logic [31:0] issue_val1;
  logic [31:0] issue_val2;
  logic [4:0]  issue_dst_vregid;

  int n_cmp = 0;
  int n_bad = 0;

  alu_reservation_station dut (
    .clk                 (clk),
    .rst                 (rst),
    .flush               (flush),
    .dispatch_en         (dispatch_en),
    .dispatch_op         (dispatch_op),
    .dispatch_rs1_ready  (dispatch_rs1_ready),
    .dispatch_rs1_vregid (dispatch_rs1_vregid),
    .dispatch_rs1_val    (dispatch_rs1_val),
    .dispatch_rs2_ready  (dispatch_rs2_ready),
    .dispatch_rs2_vregid (dispatch_rs2_vregid),
    .dispatch_rs2_val    (dispatch_rs2_val),
    .dispatch_dst_vregid (dispatch_dst_vregid),
    .full                (full),
    .wb_en               (wb_en),
    .wb_vregid           (wb_vregid),
    .wb_val              (wb_val),
    .issue_en            (issue_en),
    .issue_op            (issue_op),
    .issue_val1          (issue_val1),
    .issue_val2          (issue_val2),
    .issue_dst_vregid    (issue_dst_vregid)
  );

  always #5 clk = ~clk;

  // One row = inputs held across one rising edge + outputs expected just after it.
  typedef struct {
    logic        fl;
    logic        den;
    logic [4:0]  op;
    logic        r1r;
    logic [4:0]  r1t;
    logic [31:0] r1v;
    logic        r2r;
    logic [4:0]  r2t;
    logic [31:0] r2v;
    logic [4:0]  dst;
    logic        wen;
    logic [4:0]  wt;
    logic [31:0] wv;
    logic        ei;
    logic [4:0]  eop;
    logic [31:0] ev1;
    logic [31:0] ev2;
    logic [4:0]  edst;
    logic        efull;
  } vec_t;

  function automatic vec_t v(input bit fl, input bit den, input int op,
                             input bit r1r, input int r1t, input int r1v,
                             input bit r2r, input int r2t, input int r2v, input int dst,
                             input bit wen, input int wt, input int wv,
                             input bit ei, input int eop, input int ev1, input int ev2,
                             input int edst, input bit efull);
    vec_t r;
    r.fl = fl;  r.den = den; r.op = 5'(op);
    r.r1r = r1r; r.r1t = 5'(r1t); r.r1v = 32'(r1v);
    r.r2r = r2r; r.r2t = 5'(r2t); r.r2v = 32'(r2v);
    r.dst = 5'(dst);
    r.wen = wen; r.wt = 5'(wt); r.wv = 32'(wv);
    r.ei = ei; r.eop = 5'(eop); r.ev1 = 32'(ev1); r.ev2 = 32'(ev2);
    r.edst = 5'(edst); r.efull = efull;
    return r;
  endfunction

  function automatic vec_t idle(input bit ei, input int eop, input int ev1, input int ev2,
                                input int edst, input bit efull);
    return v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ei, eop, ev1, ev2, edst, efull);
  endfunction

  function automatic vec_t wbv(input int wt, input int wv, input bit ei, input int eop,
                               input int ev1, input int ev2, input int edst, input bit efull);
    return v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, wt, wv, ei, eop, ev1, ev2, edst, efull);
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string nm, input logic ei, input logic [4:0] eop,
                           input logic [31:0] ev1, input logic [31:0] ev2,
                           input logic [4:0] edst, input logic efull);
    cmp({nm, ".issue_en"}, 32'(issue_en), 32'(ei));
    cmp({nm, ".issue_op"}, 32'(issue_op), 32'(eop));
    cmp({nm, ".issue_val1"}, issue_val1, ev1);
    cmp({nm, ".issue_val2"}, issue_val2, ev2);
    cmp({nm, ".issue_dst"}, 32'(issue_dst_vregid), 32'(edst));
    cmp({nm, ".full"}, 32'(full), 32'(efull));
  endtask

  task automatic drive_idle();
    flush = 0; dispatch_en = 0; dispatch_op = '0;
    dispatch_rs1_ready = 0; dispatch_rs1_vregid = '0; dispatch_rs1_val = '0;
    dispatch_rs2_ready = 0; dispatch_rs2_vregid = '0; dispatch_rs2_val = '0;
    dispatch_dst_vregid = '0; wb_en = 0; wb_vregid = '0; wb_val = '0;
  endtask

  task automatic apply(input vec_t r, input string nm);
    @(negedge clk);
    flush = r.fl; dispatch_en = r.den; dispatch_op = r.op;
    dispatch_rs1_ready = r.r1r; dispatch_rs1_vregid = r.r1t; dispatch_rs1_val = r.r1v;
    dispatch_rs2_ready = r.r2r; dispatch_rs2_vregid = r.r2t; dispatch_rs2_val = r.r2v;
    dispatch_dst_vregid = r.dst; wb_en = r.wen; wb_vregid = r.wt; wb_val = r.wv;
    @(posedge clk);
    #1;
    check_all(nm, r.ei, r.eop, r.ev1, r.ev2, r.edst, r.efull);
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask

  vec_t vecs[$];

  initial begin
    rst = 1;
    drive_idle();
    #12;
    check_all("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 0;

    // Basic issue, wakeup, bypass, dual wakeup, unmatched tag, back-to-back issue.
    vecs.push_back(v(0, 1, AluAdd, 1, 0, 5, 1, 0, 7, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(idle(1, AluAdd, 5, 7, 3, 0));
    vecs.push_back(idle(0, AluAdd, 5, 7, 3, 0));
    vecs.push_back(v(0, 1, AluSub, 0, 4, 0, 1, 0, 9, 10, 0, 0, 0, 0, AluAdd, 5, 7, 3, 0));
    vecs.push_back(idle(0, AluAdd, 5, 7, 3, 0));
    vecs.push_back(wbv(4, 'h10, 0, AluAdd, 5, 7, 3, 0));
    vecs.push_back(idle(1, AluSub, 'h10, 9, 10, 0));
    vecs.push_back(v(0, 1, AluAnd, 0, 6, 0, 1, 0, 1, 11, 1, 6, 'hAB,
                     0, AluSub, 'h10, 9, 10, 0));
    vecs.push_back(idle(1, AluAnd, 'hAB, 1, 11, 0));
    vecs.push_back(v(0, 1, AluOr, 0, 2, 0, 0, 2, 0, 12, 0, 0, 0, 0, AluAnd, 'hAB, 1, 11, 0));
    vecs.push_back(wbv(2, 3, 0, AluAnd, 'hAB, 1, 11, 0));
    vecs.push_back(idle(1, AluOr, 3, 3, 12, 0));
    vecs.push_back(v(0, 1, AluXor, 0, 7, 0, 1, 0, 2, 13, 0, 0, 0, 0, AluOr, 3, 3, 12, 0));
    vecs.push_back(wbv(8, 'h55, 0, AluOr, 3, 3, 12, 0));
    vecs.push_back(idle(0, AluOr, 3, 3, 12, 0));
    vecs.push_back(wbv(7, 'h77, 0, AluOr, 3, 3, 12, 0));
    vecs.push_back(idle(1, AluXor, 'h77, 2, 13, 0));
    vecs.push_back(v(0, 1, AluAdd, 1, 0, 1, 1, 0, 2, 20, 0, 0, 0, 0, AluXor, 'h77, 2, 13, 0));
    vecs.push_back(v(0, 1, AluSub, 1, 0, 3, 1, 0, 4, 21, 0, 0, 0, 1, AluAdd, 1, 2, 20, 0));
    vecs.push_back(idle(1, AluSub, 3, 4, 21, 0));
    vecs.push_back(idle(0, AluSub, 3, 4, 21, 0));
    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], $sformatf("row%0d", i));
    end

    // Fill all slots waiting on tag 1, overflow dispatch, then drain in index order.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      apply(v(0, 1, AluAnd, 0, 1, 0, 1, 0, i, 16 + i, 0, 0, 0, 0, 0, 0, 0, 0, i == 7),
            $sformatf("fill%0d", i));
    end
    apply(v(0, 1, AluAnd, 0, 1, 0, 1, 0, 99, 31, 0, 0, 0, 0, 0, 0, 0, 0, 1), "overflow");
    apply(wbv(1, 'h42, 0, 0, 0, 0, 0, 1), "fill_wb");
    for (int k = 0; k < 8; k++) begin
      apply(idle(1, AluAnd, 'h42, k, 16 + k, 0), $sformatf("drain%0d", k));
    end
    apply(idle(0, AluAnd, 'h42, 7, 23, 0), "drain_end");

    // Flush beats both a pending issue and a same-cycle dispatch.
    do_reset();
    apply(v(0, 1, AluOr, 0, 3, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "fl_d0");
    apply(v(0, 1, AluOr, 0, 3, 0, 1, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0), "fl_d1");
    apply(v(0, 1, AluOr, 1, 0, 9, 1, 0, 9, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0), "fl_d2");
    apply(v(1, 1, AluAdd, 1, 0, 5, 1, 0, 5, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0), "flush");
    apply(wbv(3, 1, 0, 0, 0, 0, 0, 0), "fl_wb");
    for (int k = 0; k < 3; k++) begin
      apply(idle(0, 0, 0, 0, 0, 0), $sformatf("fl_idle%0d", k));
    end

    // Asynchronous reset between edges while an issue is being presented.
    do_reset();
    apply(v(0, 1, AluAdd, 1, 0, 'h33, 1, 0, 'h44, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0), "ar_d0");
    apply(v(0, 1, AluSub, 1, 0, 1, 1, 0, 1, 6, 0, 0, 0, 1, AluAdd, 'h33, 'h44, 5, 0),
          "ar_d1");
    #2 rst = 1;
    #1;
    check_all("async_rst", 0, 0, 0, 0, 0, 0);
    rst = 0;
    apply(idle(0, 0, 0, 0, 0, 0), "ar_idle0");
    apply(idle(0, 0, 0, 0, 0, 0), "ar_idle1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
